// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// cnt_width() returns the width of the per-state down-counter.
package pll_rst_pkg;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_LOCK,
      STABLE,
      REL_PERIPH,
      RUN
   } state_t;

   localparam int DEF_MIN_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 65536;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_STAGE_CYCLES   = 8;
   localparam int DEF_LOSS_CNT_W     = 8;

   // Loaded values are N-1, so clog2 of the largest N is always wide enough.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_rst_seq_bit_sync2.sv
// Generic two-flop synchroniser with synchronous active-high reset.
// Reset clears both stages, so the output reads 0 until d has been seen twice.
module bit_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the PLL: holds the PLL in reset, waits for a stable
// lock, then releases periph_rst and sys_rst in two stages.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// HOLD       | PLL and both resets asserted for MIN_RST_CYCLES
// WAIT_LOCK  | PLL released, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE     | lock seen, must stay high for STABLE_CYCLES cycles
// REL_PERIPH | periph_rst released, sys_rst held for STAGE_CYCLES cycles
// RUN        | all resets released, ready high
module pll_rst_seq
   import pll_rst_pkg::*;
#(
   parameter int MIN_RST_CYCLES = DEF_MIN_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int STAGE_CYCLES   = DEF_STAGE_CYCLES,
   parameter int LOSS_CNT_W     = DEF_LOSS_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_lock,
   input  logic                  ext_rst_req,
   output logic                  pll_rst,
   output logic                  periph_rst,
   output logic                  sys_rst,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam int CNT_W = cnt_width(MIN_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_CYCLES);

   localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(MIN_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_WAIT   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LD_STABLE = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_STAGE  = CNT_W'(STAGE_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             lock_s;
   logic             loss_inc;

   bit_sync2 u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_lock),
      .q   (lock_s)
   );

   always_comb begin
      state_n  = state;
      cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
      loss_inc = 1'b0;
      case (state)
         HOLD: begin
            // A held request keeps reloading, so HOLD only ends after it drops.
            if (ext_rst_req) begin
               cnt_n = LD_HOLD;
            end else if (cnt == '0) begin
               state_n = WAIT_LOCK;
               cnt_n   = LD_WAIT;
            end
         end
         WAIT_LOCK: begin
            if (ext_rst_req) begin
               state_n = HOLD;
               cnt_n   = LD_HOLD;
            end else if (lock_s) begin
               state_n = STABLE;
               cnt_n   = LD_STABLE;
            end else if (cnt == '0) begin
               state_n = HOLD;
               cnt_n   = LD_HOLD;
            end
         end
         STABLE: begin
            if (ext_rst_req) begin
               state_n = HOLD;
               cnt_n   = LD_HOLD;
            end else if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = LD_WAIT;
            end else if (cnt == '0) begin
               state_n = REL_PERIPH;
               cnt_n   = LD_STAGE;
            end
         end
         REL_PERIPH: begin
            // Lock loss is checked first so a coincident request still counts.
            if (!lock_s) begin
               state_n  = HOLD;
               cnt_n    = LD_HOLD;
               loss_inc = 1'b1;
            end else if (ext_rst_req) begin
               state_n = HOLD;
               cnt_n   = LD_HOLD;
            end else if (cnt == '0) begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_n  = HOLD;
               cnt_n    = LD_HOLD;
               loss_inc = 1'b1;
            end else if (ext_rst_req) begin
               state_n = HOLD;
               cnt_n   = LD_HOLD;
            end
         end
         default: begin
            state_n = HOLD;
            cnt_n   = LD_HOLD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= HOLD;
         cnt           <= LD_HOLD;
         pll_rst       <= 1'b1;
         periph_rst    <= 1'b1;
         sys_rst       <= 1'b1;
         ready         <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         pll_rst    <= (state_n == HOLD);
         periph_rst <= !((state_n == REL_PERIPH) || (state_n == RUN));
         sys_rst    <= (state_n != RUN);
         ready      <= (state_n == RUN);
         if (loss_inc && !(&lock_loss_cnt))
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq: one default-parameter instance for the full
// release timing, one short-timer instance for lock loss, timeout and saturation.
module tb_pll_rst_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b1;
   logic       ext_rst_req = 1'b0;
   logic       ext_d = 1'b0;

   logic       pll_rst, periph_rst, sys_rst, ready;
   logic [7:0] lock_loss_cnt;
   logic       pll_rst_d, periph_rst_d, sys_rst_d, ready_d;
   logic [7:0] lock_loss_cnt_d;

   int checks = 0;
   int errors = 0;
   int exp_loss;

   always #5 clk = ~clk;

   pll_rst_seq #(
      .MIN_RST_CYCLES (16),
      .LOCK_TIMEOUT   (64),
      .STABLE_CYCLES  (32),
      .STAGE_CYCLES   (8),
      .LOSS_CNT_W     (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pll_lock      (pll_lock),
      .ext_rst_req   (ext_rst_req),
      .pll_rst       (pll_rst),
      .periph_rst    (periph_rst),
      .sys_rst       (sys_rst),
      .ready         (ready),
      .lock_loss_cnt (lock_loss_cnt)
   );

   pll_rst_seq dut_def (
      .clk           (clk),
      .rst           (rst),
      .pll_lock      (pll_lock),
      .ext_rst_req   (ext_d),
      .pll_rst       (pll_rst_d),
      .periph_rst    (periph_rst_d),
      .sys_rst       (sys_rst_d),
      .ready         (ready_d),
      .lock_loss_cnt (lock_loss_cnt_d)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after the edge that entered HOLD (HOLD cnt = 15), lock high.
   task automatic check_release(input string tag);
      tick(15); chk({tag, "_pll_hi"}, pll_rst, 1);
      tick(1);  chk({tag, "_pll_lo"}, pll_rst, 0);
      chk({tag, "_periph_hold"}, periph_rst, 1);
      tick(32); chk({tag, "_periph_hi"}, periph_rst, 1);
      tick(1);  chk({tag, "_periph_lo"}, periph_rst, 0);
      chk({tag, "_sys_hold"}, sys_rst, 1);
      tick(7);  chk({tag, "_sys_hi"}, sys_rst, 1);
      tick(1);  chk({tag, "_sys_lo"}, sys_rst, 0);
      chk({tag, "_ready"}, ready, 1);
   endtask

   initial begin
      int n;
      // Reset, lock already high; the last edge with rst=1 is edge 0.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_pll", pll_rst, 1);
      chk("rst_periph", periph_rst, 1);
      chk("rst_sys", sys_rst, 1);
      chk("rst_ready", ready, 0);
      chk("rst_loss", lock_loss_cnt, 0);
      chk("rst_def_ready", ready_d, 0);

      tick(15); chk("def_pll_15", pll_rst_d, 1);
      tick(1);  chk("def_pll_16", pll_rst_d, 0);
      // Short instance: periph at 49, sys at 57.
      tick(32); chk("init_periph_48", periph_rst, 1);
      tick(1);  chk("init_periph_49", periph_rst, 0);
      tick(8);  chk("init_sys_57", sys_rst, 0);
      chk("init_ready_57", ready, 1);
      // Default instance: periph at 1041, sys/ready at 1049.
      tick(983); chk("def_periph_1040", periph_rst_d, 1);
      tick(1);   chk("def_periph_1041", periph_rst_d, 0);
      chk("def_sys_1041", sys_rst_d, 1);
      tick(7);   chk("def_sys_1048", sys_rst_d, 1);
      chk("def_ready_1048", ready_d, 0);
      tick(1);   chk("def_sys_1049", sys_rst_d, 0);
      chk("def_ready_1049", ready_d, 1);
      chk("def_loss", lock_loss_cnt_d, 0);

      // 3-cycle lock drop in RUN: resets assert 3 edges later.
      pll_lock = 1'b0;
      tick(2); chk("drop_sys_early", sys_rst, 0);
      tick(1); chk("drop_sys", sys_rst, 1);
      chk("drop_periph", periph_rst, 1);
      chk("drop_pll", pll_rst, 1);
      chk("drop_ready", ready, 0);
      chk("drop_loss", lock_loss_cnt, 1);
      pll_lock = 1'b1;
      check_release("relock");

      // Lock never returns: HOLD 16 / WAIT_LOCK 64 loop.
      pll_lock = 1'b0;
      tick(3); chk("nolock_loss", lock_loss_cnt, 2);
      tick(15); chk("nolock_pll_15", pll_rst, 1);
      tick(1);  chk("nolock_pll_16", pll_rst, 0);
      tick(63); chk("nolock_pll_79", pll_rst, 0);
      chk("nolock_periph_79", periph_rst, 1);
      tick(1);  chk("nolock_pll_80", pll_rst, 1);
      tick(15); chk("nolock_pll_95", pll_rst, 1);
      tick(1);  chk("nolock_pll_96", pll_rst, 0);
      chk("nolock_sys", sys_rst, 1);
      chk("nolock_loss2", lock_loss_cnt, 2);

      // Lock in WAIT_LOCK, STABLE at S, 2-cycle dip at S+20, STABLE again at S+25.
      pll_lock = 1'b1;
      tick(3);
      tick(20);
      pll_lock = 1'b0;
      tick(2);
      pll_lock = 1'b1;
      tick(10); chk("stab_periph_32", periph_rst, 1);
      tick(24); chk("stab_periph_56", periph_rst, 1);
      tick(1);  chk("stab_periph_57", periph_rst, 0);
      chk("stab_loss", lock_loss_cnt, 2);
      tick(8);  chk("stab_ready_65", ready, 1);

      // External request held 10 cycles in RUN.
      ext_rst_req = 1'b1;
      tick(1); chk("ext_sys", sys_rst, 1);
      chk("ext_periph", periph_rst, 1);
      chk("ext_pll", pll_rst, 1);
      chk("ext_ready", ready, 0);
      tick(9);
      ext_rst_req = 1'b0;
      check_release("ext");
      chk("ext_loss", lock_loss_cnt, 2);

      // Lock loss and request seen in the same cycle: counter still increments.
      pll_lock = 1'b0;
      tick(2);
      ext_rst_req = 1'b1;
      tick(1); chk("both_sys", sys_rst, 1);
      chk("both_loss", lock_loss_cnt, 3);
      ext_rst_req = 1'b0;
      pll_lock = 1'b1;
      check_release("both");

      // 300 forced losses, saturating at 255.
      exp_loss = 3;
      for (int i = 0; i < 300; i++) begin
         n = 0;
         while (periph_rst !== 1'b0 && n < 200) begin
            tick(1);
            n++;
         end
         chk("sat_reach_rel", (n < 200), 1);
         pll_lock = 1'b0;
         tick(3);
         pll_lock = 1'b1;
         exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
         chk("sat_loss", lock_loss_cnt, exp_loss);
      end
      chk("sat_final", lock_loss_cnt, 255);

      // rst mid-STABLE.
      tick(27); chk("mid_pll_pre", pll_rst, 0);
      rst = 1'b1;
      tick(1);
      chk("mid_pll", pll_rst, 1);
      chk("mid_periph", periph_rst, 1);
      chk("mid_sys", sys_rst, 1);
      chk("mid_ready", ready, 0);
      chk("mid_loss", lock_loss_cnt, 0);
      rst = 1'b0;
      check_release("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
